// File: rtl/seq_multiplier_32bits_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and sizing constants used by the top and its adder.
package seq_multiplier_32bits_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER  = 32;
  localparam int CNT_W     = 5;

  // 2'b11 is unused and is handled as IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_multiplier_32bits_adder32_carry.sv
// 32-bit unsigned adder with carry-out; forms one partial-product step
// (acc_hi + selected multiplicand) of the shift-add multiplier.
module adder32_carry
  import seq_multiplier_32bits_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a_i,
  input  logic [MUL_WIDTH-1:0] b_i,
  output logic [MUL_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [MUL_WIDTH:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = full_sum[MUL_WIDTH-1:0];
  assign carry_o  = full_sum[MUL_WIDTH];

endmodule

// File: rtl/seq_multiplier_32bits.sv
// Sequential unsigned 32x32 shift-add multiplier: one partial-product step per
// clock, 64-bit result held in registers until the next completion.
module seq_multiplier_32bits
  import seq_multiplier_32bits_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int ITER  = MUL_ITER
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             overflow,
  output state_e           dbg_state_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] mcand_q,    mcand_d;
  logic [WIDTH-1:0] mplier_q,   mplier_d;
  logic [WIDTH-1:0] acc_hi_q,   acc_hi_d;
  logic [WIDTH-1:0] prod_lo_q,  prod_lo_d;
  logic [WIDTH-1:0] prod_hi_q,  prod_hi_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] step_sum;
  logic             step_carry;
  logic [WIDTH-1:0] acc_hi_next;
  logic [WIDTH-1:0] mplier_next;

  assign addend = mplier_q[0] ? mcand_q : '0;

  adder32_carry u_adder (
    .a_i     (acc_hi_q),
    .b_i     (addend),
    .sum_o   (step_sum),
    .carry_o (step_carry)
  );

  // {c, sum, mplier} shifted right by one: the adder's LSB drops into the
  // multiplier register as the next settled product bit.
  assign acc_hi_next = {step_carry, step_sum[WIDTH-1:1]};
  assign mplier_next = {step_sum[0], mplier_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_hi_d   = acc_hi_q;
    prod_lo_d  = prod_lo_q;
    prod_hi_d  = prod_hi_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_BUSY: begin
        acc_hi_d = acc_hi_next;
        mplier_d = mplier_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d    = ST_DONE;
          prod_hi_d  = acc_hi_next;
          prod_lo_d  = mplier_next;
          overflow_d = |acc_hi_next;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        if (start) begin
          state_d  = ST_BUSY;
          mcand_d  = a;
          mplier_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_hi_q   <= '0;
      prod_lo_q  <= '0;
      prod_hi_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_hi_q   <= acc_hi_d;
      prod_lo_q  <= prod_lo_d;
      prod_hi_q  <= prod_hi_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy        = (state_q == ST_BUSY);
  assign done        = (state_q == ST_DONE);
  assign product_lo  = prod_lo_q;
  assign product_hi  = prod_hi_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_multiplier_32bits.sv
// Directed bench for seq_multiplier_32bits: stimulus pushes hand-computed
// {overflow, product_hi, product_lo} into a queue; a monitor pops on done.
module tb_seq_multiplier_32bits;
  import seq_multiplier_32bits_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product_lo;
  logic [31:0] product_hi;
  logic        overflow;
  state_e      dbg_state;

  seq_multiplier_32bits dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product_lo  (product_lo),
    .product_hi  (product_hi),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [64:0] exp_q[$];
  logic [64:0] last_res = '0;
  logic [64:0] mon_exp;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("busy_during_done", 65'(busy), 65'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", {overflow, product_hi, product_lo}, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [64:0] ev, input bit push);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) exp_q.push_back(ev);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 65'(busy), 65'd1);
  endtask

  // Waits for done starting just after E0; optionally hammers start/a/b from E10.
  task automatic wait_done(input logic [64:0] ev, input bit noisy);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check("result_hold_busy", {overflow, product_hi, product_lo}, last_res);
      if (done === 1'b1) begin
        seen  = 1'b1;
        start = 1'b0;
        break;
      end
      if (noisy && k >= 9) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done at E32");
    end else begin
      check("done_latency", 65'(k), 65'd32);
    end
    last_res = ev;
    @(posedge clk);
    #1;
    check("done_one_cycle", 65'(done), 65'd0);
    repeat (2) @(posedge clk);
    #1;
    check("result_hold_idle", {overflow, product_hi, product_lo}, last_res);
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic [64:0] ev);
    issue(av, bv, ev, 1'b1);
    wait_done(ev, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    a       = 32'd3;
    b       = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 65'(busy), 65'd0);
    check("reset_done", 65'(done), 65'd0);
    check("reset_result", {overflow, product_hi, product_lo}, 65'd0);
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, {1'b0, 32'h0, 32'd15});
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b1, 32'hFFFF_FFFE, 32'h0000_0001});
    run_op(32'h0001_0000, 32'h0001_0000, {1'b1, 32'h0000_0001, 32'h0000_0000});
    run_op(32'h0, 32'hDEAD_BEEF, {1'b0, 32'h0, 32'h0});
    run_op(32'hFFFF_FFFF, 32'd1, {1'b0, 32'h0, 32'hFFFF_FFFF});
    run_op(32'hFFFF_FFFF, 32'd2, {1'b1, 32'h0000_0001, 32'hFFFF_FFFE});
    run_op(32'h8000_0000, 32'h8000_0000, {1'b1, 32'h4000_0000, 32'h0000_0000});

    // start and operand changes while busy must be ignored
    issue(32'd7, 32'd6, {1'b0, 32'h0, 32'd42}, 1'b1);
    wait_done({1'b0, 32'h0, 32'd42}, 1'b1);

    // reset in flight: no done, outputs cleared at E10
    issue(32'd9, 32'd9, 65'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_busy", 65'(busy), 65'd0);
    check("midreset_done", 65'(done), 65'd0);
    check("midreset_result", {overflow, product_hi, product_lo}, 65'd0);
    check("midreset_state", 65'(dbg_state), 65'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    last_res = '0;
    repeat (40) @(posedge clk);
    run_op(32'd4, 32'd4, {1'b0, 32'h0, 32'd16});

    repeat (5) @(negedge clk);
    check("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
